// File: rtl/sad_accum.sv
// Sum-of-absolute-differences accumulator: one |a-b| per accepted sample, summed
// over COUNT samples and presented with a valid/ready handshake.
module sad_accum #(
  parameter  int WIDTH = 4,
  parameter  int COUNT = 4,
  localparam int SUM_W = WIDTH + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] dif_out,
  output logic             dif_valid,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             dif_valid_q, dif_valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  logic [WIDTH-1:0] abs_dif;
  logic [SUM_W-1:0] frame_sum;

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    abs_dif   = (a_in >= b_in) ? (a_in - b_in) : (b_in - a_in);
    frame_sum = acc_q + SUM_W'(abs_dif);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dif_d       = dif_q;
    dif_valid_d = 1'b0;
    sum_d       = sum_q;

    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      sum_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            dif_d       = abs_dif;
            dif_valid_d = 1'b1;
            // The final sample goes straight into sum_q so the total is ready with its dif pulse.
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              sum_d   = frame_sum;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = frame_sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      dif_q       <= '0;
      dif_valid_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dif_q       <= dif_d;
      dif_valid_q <= dif_valid_d;
      sum_q       <= sum_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign sum_valid = (state_q == DONE);
  assign dif_out   = dif_q;
  assign dif_valid = dif_valid_q;
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_sad_accum.sv
// Self-checking bench for sad_accum: directed scenarios plus randomized frames,
// checked against a frame-level arithmetic model of the SAD result.
module tb_sad_accum;

  logic clk;
  logic rst_n;

  // Instance A: WIDTH=4, COUNT=4
  logic       clr_a, in_valid_a, in_ready_a, sum_ready_a;
  logic [3:0] a_a, b_a, dif_a;
  logic       difv_a, sumv_a;
  logic [5:0] sum_a;

  // Instance B: WIDTH=8, COUNT=5
  logic        clr_b, in_valid_b, in_ready_b, sum_ready_b;
  logic [7:0]  a_b, b_b, dif_b;
  logic        difv_b, sumv_b;
  logic [10:0] sum_b;

  int checks;
  int errors;

  sad_accum #(.WIDTH(4), .COUNT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .a_in(a_a), .b_in(b_a), .dif_out(dif_a), .dif_valid(difv_a),
    .sum_out(sum_a), .sum_valid(sumv_a), .sum_ready(sum_ready_a)
  );

  sad_accum #(.WIDTH(8), .COUNT(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .a_in(a_b), .b_in(b_b), .dif_out(dif_b), .dif_valid(difv_b),
    .sum_out(sum_b), .sum_valid(sumv_b), .sum_ready(sum_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_abs(input int a, input int b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Advance one clock and settle just after the active edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (sum_a !== 6'd0)  begin errors++; $display("[TB] FAIL reset_sum: got %0d expected 0", sum_a); end
    if (sumv_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_sumv: got %b expected 0", sumv_a); end
    if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_difv: got %b expected 0", difv_a); end
    if (dif_a !== 4'd0)  begin errors++; $display("[TB] FAIL reset_dif: got %0d expected 0", dif_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready_a); end
    checks += 2;
    if (sum_b !== 11'd0) begin errors++; $display("[TB] FAIL reset_sum_b: got %0d expected 0", sum_b); end
    if (in_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_b: got %b expected 1", in_ready_b); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feeds a full frame into A back to back, checking every dif pulse and the final sum.
  task automatic feed_frame_a(input string name, input int av[4], input int bv[4]);
    int exp_sum;
    exp_sum = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid_a = 1'b1; a_a = 4'(av[i]); b_a = 4'(bv[i]);
      exp_sum += ref_abs(av[i], bv[i]);
      cycle();
      checks += 3;
      if (difv_a !== 1'b1) begin errors++; $display("[TB] FAIL %s_difv%0d: got %b expected 1", name, i, difv_a); end
      if (dif_a !== 4'(ref_abs(av[i], bv[i]))) begin
        errors++; $display("[TB] FAIL %s_dif%0d: got %0d expected %0d", name, i, dif_a, ref_abs(av[i], bv[i]));
      end
      if (sumv_a !== (i == 3)) begin errors++; $display("[TB] FAIL %s_sumv%0d: got %b expected %b", name, i, sumv_a, i == 3); end
    end
    in_valid_a = 1'b0;
    checks++;
    if (sum_a !== 6'(exp_sum)) begin errors++; $display("[TB] FAIL %s_sum: got %0d expected %0d", name, sum_a, exp_sum); end
  endtask

  task automatic handshake_a(input string name);
    sum_ready_a = 1'b1;
    cycle();
    sum_ready_a = 1'b0;
    checks += 2;
    if (sumv_a !== 1'b0) begin errors++; $display("[TB] FAIL %s_hs_sumv: got %b expected 0", name, sumv_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL %s_hs_ready: got %b expected 1", name, in_ready_a); end
  endtask

  task automatic test_back_to_back();
    int av[4] = '{3, 10, 5, 12};
    int bv[4] = '{12, 4, 5, 0};
    feed_frame_a("b2b", av, bv);
    for (int k = 0; k < 3; k++) begin
      in_valid_a = 1'b1; a_a = 4'($urandom_range(15)); b_a = 4'($urandom_range(15));
      cycle();
      checks += 4;
      if (sum_a !== 6'd27) begin errors++; $display("[TB] FAIL b2b_hold_sum: got %0d expected 27", sum_a); end
      if (sumv_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold_sumv: got %b expected 1", sumv_a); end
      if (in_ready_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_ready: got %b expected 0", in_ready_a); end
      if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_difv: got %b expected 0", difv_a); end
    end
    in_valid_a = 1'b0;
    handshake_a("b2b");
  endtask

  task automatic test_worst_case();
    int av1[4] = '{15, 15, 15, 15};
    int bv1[4] = '{0, 0, 0, 0};
    feed_frame_a("worst1", av1, bv1);
    handshake_a("worst1");
    feed_frame_a("worst2", bv1, av1);
    handshake_a("worst2");
  endtask

  task automatic test_gaps();
    int av[4] = '{7, 2, 0, 1};
    int bv[4] = '{2, 7, 0, 0};
    int exp_sum;
    exp_sum = ref_abs(av[0], bv[0]);
    in_valid_a = 1'b1; a_a = 4'(av[0]); b_a = 4'(bv[0]);
    cycle();
    for (int k = 0; k < 3; k++) begin
      in_valid_a = 1'b0; a_a = 4'($urandom_range(15)); b_a = 4'($urandom_range(15));
      cycle();
      checks++;
      if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL gap_idle_difv%0d: got %b expected 0", k, difv_a); end
    end
    for (int i = 1; i < 4; i++) begin
      in_valid_a = 1'b1; a_a = 4'(av[i]); b_a = 4'(bv[i]);
      exp_sum += ref_abs(av[i], bv[i]);
      cycle();
    end
    in_valid_a = 1'b0;
    checks += 2;
    if (sumv_a !== 1'b1) begin errors++; $display("[TB] FAIL gap_sumv: got %b expected 1", sumv_a); end
    if (sum_a !== 6'(exp_sum)) begin errors++; $display("[TB] FAIL gap_sum: got %0d expected %0d", sum_a, exp_sum); end
    handshake_a("gap");
  endtask

  task automatic test_clr();
    int av[4] = '{4, 4, 4, 4};
    in_valid_a = 1'b1; a_a = 4'd8; b_a = 4'd1; cycle();
    a_a = 4'd1; b_a = 4'd8; cycle();
    clr_a = 1'b1; a_a = 4'd9; b_a = 4'd0;
    cycle();
    clr_a = 1'b0; in_valid_a = 1'b0;
    checks += 3;
    if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL clr_difv: got %b expected 0", difv_a); end
    if (sumv_a !== 1'b0) begin errors++; $display("[TB] FAIL clr_sumv: got %b expected 0", sumv_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL clr_ready: got %b expected 1", in_ready_a); end
    feed_frame_a("clr", av, av);
    handshake_a("clr");
  endtask

  task automatic test_async_reset();
    int av[4] = '{3, 10, 5, 12};
    int bv[4] = '{12, 4, 5, 0};
    int ones[4] = '{1, 1, 1, 1};
    int zeros[4] = '{0, 0, 0, 0};
    feed_frame_a("arst_pre", av, bv);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (sum_a !== 6'd0)  begin errors++; $display("[TB] FAIL arst_sum: got %0d expected 0", sum_a); end
    if (sumv_a !== 1'b0) begin errors++; $display("[TB] FAIL arst_sumv: got %b expected 0", sumv_a); end
    if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL arst_difv: got %b expected 0", difv_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got %b expected 1", in_ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    feed_frame_a("arst_post", ones, zeros);
    handshake_a("arst_post");
  endtask

  // Random frames with idle gaps, ignored sum_ready in ACC and offered samples during DONE.
  task automatic test_random_frames();
    int exp_sum, n, x, y, hold;
    for (int f = 0; f < 8; f++) begin
      exp_sum = 0; n = 0;
      while (n < 4) begin
        sum_ready_a = 1'($urandom_range(1));
        if ($urandom_range(3) == 0) begin
          in_valid_a = 1'b0; a_a = 4'($urandom_range(15)); b_a = 4'($urandom_range(15));
          cycle();
          checks += 2;
          if (difv_a !== 1'b0) begin errors++; $display("[TB] FAIL rnd_idle_difv f%0d: got %b expected 0", f, difv_a); end
          if (sumv_a !== 1'b0) begin errors++; $display("[TB] FAIL rnd_idle_sumv f%0d: got %b expected 0", f, sumv_a); end
        end else begin
          x = $urandom_range(15); y = $urandom_range(15);
          in_valid_a = 1'b1; a_a = 4'(x); b_a = 4'(y);
          exp_sum += ref_abs(x, y);
          n++;
          cycle();
          checks += 2;
          if (difv_a !== 1'b1 || dif_a !== 4'(ref_abs(x, y))) begin
            errors++; $display("[TB] FAIL rnd_dif f%0d: got %0d/%b expected %0d/1", f, dif_a, difv_a, ref_abs(x, y));
          end
          if (sumv_a !== (n == 4)) begin errors++; $display("[TB] FAIL rnd_sumv f%0d n%0d: got %b expected %b", f, n, sumv_a, n == 4); end
        end
      end
      sum_ready_a = 1'b0;
      checks++;
      if (sum_a !== 6'(exp_sum)) begin errors++; $display("[TB] FAIL rnd_sum f%0d: got %0d expected %0d", f, sum_a, exp_sum); end
      hold = $urandom_range(3);
      for (int k = 0; k < hold; k++) begin
        in_valid_a = 1'($urandom_range(1)); a_a = 4'($urandom_range(15)); b_a = 4'($urandom_range(15));
        cycle();
        checks += 2;
        if (sum_a !== 6'(exp_sum) || sumv_a !== 1'b1) begin
          errors++; $display("[TB] FAIL rnd_hold f%0d: got %0d/%b expected %0d/1", f, sum_a, sumv_a, exp_sum);
        end
        if (in_ready_a !== 1'b0 || difv_a !== 1'b0) begin
          errors++; $display("[TB] FAIL rnd_hold_ctl f%0d: got ready %b difv %b expected 0 0", f, in_ready_a, difv_a);
        end
      end
      in_valid_a = 1'($urandom_range(1));
      handshake_a("rnd");
      in_valid_a = 1'b0;
    end
  endtask

  task automatic test_wide();
    int exp_sum;
    exp_sum = 0;
    in_valid_b = 1'b1; a_b = 8'd255; b_b = 8'd0;
    for (int i = 0; i < 5; i++) begin
      exp_sum += ref_abs(255, 0);
      cycle();
    end
    checks += 2;
    if (sumv_b !== 1'b1) begin errors++; $display("[TB] FAIL wide_sumv: got %b expected 1", sumv_b); end
    if (sum_b !== 11'(exp_sum)) begin errors++; $display("[TB] FAIL wide_sum: got %0d expected %0d", sum_b, exp_sum); end
    for (int k = 0; k < 3; k++) begin
      a_b = 8'd10; b_b = 8'd3;
      cycle();
      checks += 2;
      if (in_ready_b !== 1'b0 || difv_b !== 1'b0) begin
        errors++; $display("[TB] FAIL wide_done_ctl: got ready %b difv %b expected 0 0", in_ready_b, difv_b);
      end
      if (sum_b !== 11'(exp_sum)) begin errors++; $display("[TB] FAIL wide_done_sum: got %0d expected %0d", sum_b, exp_sum); end
    end
    sum_ready_b = 1'b1;
    cycle();
    sum_ready_b = 1'b0;
    exp_sum = 0;
    for (int i = 0; i < 5; i++) begin
      exp_sum += ref_abs(10, 3);
      cycle();
    end
    in_valid_b = 1'b0;
    checks += 2;
    if (sumv_b !== 1'b1) begin errors++; $display("[TB] FAIL wide2_sumv: got %b expected 1", sumv_b); end
    if (sum_b !== 11'(exp_sum)) begin errors++; $display("[TB] FAIL wide2_sum: got %0d expected %0d", sum_b, exp_sum); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    clr_a = 1'b0; in_valid_a = 1'b0; sum_ready_a = 1'b0; a_a = '0; b_a = '0;
    clr_b = 1'b0; in_valid_b = 1'b0; sum_ready_b = 1'b0; a_b = '0; b_b = '0;
    test_reset();
    test_back_to_back();
    test_worst_case();
    test_gaps();
    test_clr();
    test_async_reset();
    test_random_frames();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
